uart_rx_engine: RTL and testbench

//  Parametrised UART receive engine: oversampled RX line in, parallel word plus status out.

---
 rtl/uart_rx_engine.sv | 154 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled RX line in, parallel word plus frame status out.
// Majority-of-three bit sampling, optional parity, 1 or 2 stop bits, saturating error counter.
module uart_rx_engine #(
  parameter int DATA_W   = 8,
  parameter int PRESC_W  = 6,
  parameter int ERRCNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic [PRESC_W-1:0]  Prescale,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic                STOP2,
  output logic [DATA_W-1:0]   P_DATA,
  output logic                data_valid,
  output logic                par_err,
  output logic                stp_err,
  output logic                strt_glitch,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [PRESC_W-1:0] ONE       = 1;
  localparam logic [3:0]         LAST_DATA = 4'(DATA_W);

  state_t              state, state_nxt;
  logic [PRESC_W-1:0]  presc_q;
  logic                par_en_q, par_typ_q, stop2_q;
  logic [PRESC_W-1:0]  edge_cnt;
  logic [3:0]          bit_cnt;
  logic                smp0, smp1, smp_bit;
  logic [DATA_W-1:0]   shreg;
  logic                par_flag, stp_flag;

  logic [PRESC_W-1:0]  half;
  logic                bit_end, data_last, stop_last, in_frame;
  logic                start_go, par_bad, stp_now, frame_end;

  always_comb begin
    half      = presc_q >> 1;
    bit_end   = (edge_cnt == presc_q - ONE);
    data_last = (bit_cnt == LAST_DATA);
    // bit_cnt 0 is the start bit, so the last stop bit sits after data, parity and stop count
    stop_last = (bit_cnt == LAST_DATA + 4'(par_en_q) + 4'(stop2_q) + 4'd1);
    in_frame  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    start_go  = ((state == IDLE) || (state == DONE)) && !RX_IN;
    par_bad   = (smp_bit != ((^shreg) ^ par_typ_q));
    stp_now   = stp_flag | ~smp_bit;
    frame_end = (state == STOP) && bit_end && stop_last;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (bit_end) state_nxt = smp_bit ? IDLE : DATA;
      DATA:    if (bit_end && data_last) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && stop_last) state_nxt = DONE;
      DONE:    state_nxt = RX_IN ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      smp0        <= 1'b1;
      smp1        <= 1'b1;
      smp_bit     <= 1'b1;
      shreg       <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      err_cnt     <= '0;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;

      if (start_go) begin
        presc_q   <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
        edge_cnt  <= '0;
        bit_cnt   <= '0;
        par_flag  <= 1'b0;
        stp_flag  <= 1'b0;
      end else if (in_frame) begin
        if (bit_end) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + ONE;
        end

        if (edge_cnt == half - ONE) smp0 <= RX_IN;
        if (edge_cnt == half)       smp1 <= RX_IN;
        if (edge_cnt == half + ONE)
          smp_bit <= (smp0 & smp1) | (smp0 & RX_IN) | (smp1 & RX_IN);

        if (bit_end) begin
          case (state)
            START:  if (smp_bit) strt_glitch <= 1'b1;
            DATA:   shreg <= {smp_bit, shreg[DATA_W-1:1]};
            PARITY: if (par_bad) par_flag <= 1'b1;
            STOP:   if (!smp_bit) stp_flag <= 1'b1;
            default: ;
          endcase
        end

        if (frame_end) begin
          if (!par_flag && !stp_now) begin
            P_DATA     <= shreg;
            data_valid <= 1'b1;
          end else begin
            par_err <= par_flag;
            stp_err <= stp_now;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: drives hand-built serial frames and checks word,
// status pulses and error counter against hand-computed values.
module tb_uart_rx_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err, strt_glitch, busy;
  logic [1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int dv_n = 0, pe_n = 0, se_n = 0, gl_n = 0, both_n = 0;
  logic [7:0] dv_log [0:31];

  uart_rx_engine #(.DATA_W(8), .PRESC_W(6), .ERRCNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .strt_glitch(strt_glitch), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  // pulse widths are counted in cycles high, so a stretched pulse shows up as an extra count
  always @(negedge CLK) begin
    if (!RST) begin
      if (data_valid) begin
        dv_log[dv_n[4:0]] = P_DATA;
        dv_n++;
      end
      if (par_err) pe_n++;
      if (stp_err) se_n++;
      if (strt_glitch) gl_n++;
      if (data_valid && (par_err || stp_err)) both_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input bit pen, input bit pbit,
                            input int nstop, input bit last_stop, input int noise_bit);
    int nbits;
    logic v;
    nbits = 1 + 8 + (pen ? 1 : 0) + nstop;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                 v = 1'b0;
      else if (b <= 8)            v = d[b-1];
      else if (pen && b == 9)     v = pbit;
      else if (b == nbits - 1)    v = last_stop;
      else                        v = 1'b1;
      for (int c = 0; c < p; c++) begin
        RX_IN = (b == noise_bit && c == p / 2 + 1) ? ~v : v;
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    @(negedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_pulses", {data_valid, par_err, stp_err, strt_glitch}, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // T1: P=8, 8N1, 0xA5
    Prescale = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    send_frame(8, 8'hA5, 0, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t1_dv_count", dv_n, 1);
    check("t1_pdata", P_DATA, 8'hA5);
    check("t1_busy", busy, 0);
    check("t1_errcnt", err_cnt, 0);

    // T2: P=16, even parity, 0x37 has odd popcount so correct parity is 1; send 0
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(16, 8'h37, 1, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t2_par_err", pe_n, 1);
    check("t2_stp_err", se_n, 0);
    check("t2_dv_count", dv_n, 1);
    check("t2_pdata_held", P_DATA, 8'hA5);
    check("t2_errcnt", err_cnt, 1);

    // T3: P=8, two stop bits, second stop driven low, then clean 0x5A
    Prescale = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b1;
    send_frame(8, 8'h3C, 0, 0, 2, 0, -1);
    repeat (6) @(negedge CLK);
    check("t3_stp_err", se_n, 1);
    check("t3_errcnt", err_cnt, 2);
    check("t3_pdata_held", P_DATA, 8'hA5);
    send_frame(8, 8'h5A, 0, 0, 2, 1, -1);
    repeat (6) @(negedge CLK);
    check("t3_dv_count", dv_n, 2);
    check("t3_pdata", P_DATA, 8'h5A);
    check("t3_errcnt_kept", err_cnt, 2);

    // T4: 3-cycle low blip at P=16
    Prescale = 6'd16; STOP2 = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (24) @(negedge CLK);
    check("t4_glitch", gl_n, 1);
    check("t4_busy", busy, 0);
    check("t4_dv_count", dv_n, 2);
    check("t4_errcnt", err_cnt, 2);

    // T5: back-to-back 0x01 (noise on centre of data bit 1) and 0xFE
    Prescale = 6'd8;
    send_frame(8, 8'h01, 0, 0, 1, 1, 2);
    send_frame(8, 8'hFE, 0, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t5_dv_count", dv_n, 4);
    check("t5_word0", dv_log[2], 8'h01);
    check("t5_word1", dv_log[3], 8'hFE);
    check("t5_pdata", P_DATA, 8'hFE);
    check("t5_busy", busy, 0);

    // T6a: two more bad-parity frames saturate a 2-bit counter at 3
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8, 8'h37, 1, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t6_errcnt_max", err_cnt, 3);
    send_frame(8, 8'h37, 1, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t6_errcnt_sat", err_cnt, 3);
    check("t6_par_err", pe_n, 3);
    check("t6_no_overlap", both_n, 0);

    // T6b: reset mid-DATA
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (16) @(negedge CLK);
    check("t6_busy_before_rst", busy, 1);
    RST = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pdata", P_DATA, 0);
    check("t6_rst_errcnt", err_cnt, 0);
    check("t6_rst_pulses", {data_valid, par_err, stp_err, strt_glitch}, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("t6_no_pulse_after_rst", dv_n + pe_n + se_n + gl_n, 4 + 3 + 1 + 1);
    send_frame(8, 8'hC3, 0, 0, 1, 1, -1);
    repeat (6) @(negedge CLK);
    check("t6_recover_dv", dv_n, 5);
    check("t6_recover_pdata", P_DATA, 8'hC3);
    check("t6_recover_errcnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
